// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID checker: FSM state codes, slave word
// addresses and the stall-counter width helper.
package sysid_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD_ID  = 3'd1;
  localparam state_t ST_RD_TS  = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Bits needed to count 0 .. v-1 (never less than 1).
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/sysid_stall_timer.sv
// Counts consecutive waitrequest cycles of one read; expired flags the stall
// cycle on which the read must be abandoned.
module sysid_stall_timer
  import sysid_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = clog2(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/sysid_checker.sv
// Boot-time system-ID verifier: reads ID and build timestamp from the sysid
// slave over Avalon-MM and reports match/mismatch/timeout.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h8765_4321,
  parameter logic [31:0] EXPECTED_TS    = 32'h694F_E217,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter bit          AUTOSTART      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state;
  logic   auto_pend;
  logic   stall_clear, stall_en, stall_expired;

  // Counter restarts on entry to each read: held clear in IDLE, and cleared
  // again as the ID read completes.
  assign stall_clear = (state == ST_IDLE) || (state == ST_RD_ID && !avm_waitrequest);
  assign stall_en    = (state == ST_RD_ID || state == ST_RD_TS) && avm_waitrequest;

  sysid_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_stall (
    .clock   (clock),
    .reset   (reset),
    .clear   (stall_clear),
    .enable  (stall_en),
    .expired (stall_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      auto_pend   <= AUTOSTART;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || auto_pend) begin
            state       <= ST_RD_ID;
            auto_pend   <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (!avm_waitrequest) begin
            id_value    <= avm_readdata;
            avm_address <= SYSID_ADDR_TS;
            state       <= ST_RD_TS;
          end else if (stall_expired) begin
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value <= avm_readdata;
            avm_read <= 1'b0;
            state    <= ST_CHECK;
          end else if (stall_expired) begin
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_CHECK: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TS);
          done  <= 1'b1;
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          avm_read <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
